// File: rtl/processor_if.sv
// processor_if.sv - data-memory bus between the core datapath and its data RAM.
// Async read (rdata follows addr in the same cycle), synchronous write on the
// rising clock edge when we is high.

interface processor_if;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;

    modport master (output we, output addr, output wdata, input  rdata);
    modport slave  (input  we, input  addr, input  wdata, output rdata);
endinterface

// File: rtl/processor.sv
// processor.sv - single-cycle 16-bit load/store CPU: PC, instruction ROM,
// 8x16 register file, ALU, data RAM and control decode. One instruction
// retires per clock; register/memory writes land on the edge the PC advances.
// Optional feature macro: HALT_EN (opcode 4'b1111 halts the core until reset;
// when undefined 4'b1111 is a NOP like 4'b1000-4'b1110).
// The instruction image is preloaded into imem by the environment; words not
// loaded read as 16'h0000 (ADD r0,r0,r0, which is a NOP since r0 is fixed).

module processor_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_we,
    input  logic [2:0]  i_waddr,
    input  logic [15:0] i_wdata,
    input  logic [2:0]  i_raddr_a,
    input  logic [2:0]  i_raddr_b,
    output logic [15:0] o_rdata_a,
    output logic [15:0] o_rdata_b
);
    logic [15:0] reg_file [0:7];

    // Register write port; r0 is never written so it stays at its reset value of 0.
    // NOTE: state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) reg_file[i] <= '0;
        end else if (i_we && (i_waddr != 3'd0)) begin
            reg_file[i_waddr] <= i_wdata;
        end
    end

    // r0 reads as zero regardless of storage contents (e.g. before first reset).
    assign o_rdata_a = (i_raddr_a == 3'd0) ? 16'h0000 : reg_file[i_raddr_a];
    assign o_rdata_b = (i_raddr_b == 3'd0) ? 16'h0000 : reg_file[i_raddr_b];
endmodule

module processor_dmem #(
    parameter int DEPTH = 256
) (
    input  logic           clk,
    processor_if.slave     bus
);
    logic [15:0] mem [0:DEPTH-1];

    // Synchronous write port.
    // NOTE: the data RAM deliberately has no reset; contents survive a core reset.
    always_ff @(posedge clk) begin
        if (bus.we) mem[bus.addr] <= bus.wdata;
    end

    // A load issued the cycle after a store sees the stored value because the
    // write has already completed on the preceding edge.
    assign bus.rdata = mem[bus.addr];
endmodule

module processor #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic clk,
    input  logic reset
);
    localparam int IAW = $clog2(IMEM_DEPTH);

    typedef enum logic [3:0] {
        OP_RTYPE = 4'h0,
        OP_ADDI  = 4'h1,
        OP_LW    = 4'h2,
        OP_SW    = 4'h3,
        OP_BEQ   = 4'h4,
        OP_BNE   = 4'h5,
        OP_JMP   = 4'h6,
        OP_LUI   = 4'h7,
        OP_HALT  = 4'hF
    } opcode_e;

    logic [15:0] pc;
    logic [15:0] instruction;
    logic [3:0]  opcode;
    logic [15:0] imem [0:IMEM_DEPTH-1] = '{default: 16'h0000};

    logic [2:0]  w_rd, w_rs, w_rt, w_funct;
    logic [15:0] w_imm6, w_imm12;
    logic [15:0] w_rdata_a, w_rdata_b;
    logic [15:0] w_alu_r, w_addr_sum, w_pc_inc;
    logic [15:0] w_pc_next, w_reg_wdata;
    logic        w_reg_we;

    processor_if dmem_bus ();

    // Fetch and field extraction.
    assign instruction = imem[pc[IAW-1:0]];
    assign opcode      = instruction[15:12];
    assign w_rd        = instruction[11:9];
    assign w_rs        = instruction[8:6];
    assign w_rt        = instruction[5:3];
    assign w_funct     = instruction[2:0];
    assign w_imm6      = {{10{instruction[5]}}, instruction[5:0]};
    assign w_imm12     = {4'h0, instruction[11:0]};

    // Port B reads rt for R-type, otherwise rd (branch compare / store data).
    processor_regfile regfile (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_reg_we),
        .i_waddr   (w_rd),
        .i_wdata   (w_reg_wdata),
        .i_raddr_a (w_rs),
        .i_raddr_b ((opcode == OP_RTYPE) ? w_rt : w_rd),
        .o_rdata_a (w_rdata_a),
        .o_rdata_b (w_rdata_b)
    );

    processor_dmem #(.DEPTH(DMEM_DEPTH)) dmem (
        .clk (clk),
        .bus (dmem_bus)
    );

    assign w_addr_sum     = w_rdata_a + w_imm6;
    assign w_pc_inc       = pc + 16'd1;
    assign dmem_bus.addr  = w_addr_sum[7:0];
    assign dmem_bus.wdata = w_rdata_b;
    assign dmem_bus.we    = (opcode == OP_SW) && !reset;

    // R-type ALU: arithmetic wraps in 16 bits, SLT compares as signed.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_alu_r = 16'h0000;
        case (w_funct)
            3'b000: w_alu_r = w_rdata_a + w_rdata_b;
            3'b001: w_alu_r = w_rdata_a - w_rdata_b;
            3'b010: w_alu_r = w_rdata_a & w_rdata_b;
            3'b011: w_alu_r = w_rdata_a | w_rdata_b;
            3'b100: w_alu_r = w_rdata_a ^ w_rdata_b;
            3'b101: w_alu_r = {15'h0000, ($signed(w_rdata_a) < $signed(w_rdata_b))};
            3'b110: w_alu_r = w_rdata_a << w_rdata_b[3:0];
            3'b111: w_alu_r = w_rdata_a >> w_rdata_b[3:0];
            default: w_alu_r = 16'h0000;
        endcase
    end

    // Control decode: register write enable/data and next PC.
    always_comb begin
        w_reg_we    = 1'b0;
        w_reg_wdata = w_alu_r;
        w_pc_next   = w_pc_inc;
        case (opcode)
            OP_RTYPE: w_reg_we = 1'b1;
            OP_ADDI: begin
                w_reg_we    = 1'b1;
                w_reg_wdata = w_addr_sum;
            end
            OP_LW: begin
                w_reg_we    = 1'b1;
                w_reg_wdata = dmem_bus.rdata;
            end
            OP_BEQ: if (w_rdata_b == w_rdata_a) w_pc_next = w_pc_inc + w_imm6;
            OP_BNE: if (w_rdata_b != w_rdata_a) w_pc_next = w_pc_inc + w_imm6;
            OP_JMP: w_pc_next = w_imm12;
            OP_LUI: begin
                w_reg_we    = 1'b1;
                w_reg_wdata = {instruction[7:0], 8'h00};
            end
`ifdef HALT_EN
            OP_HALT: w_pc_next = pc;
`else
`endif
            default: ;
        endcase
    end

    // Program counter: counts freely; only its low bits address imem.
    always_ff @(posedge clk) begin
        if (reset) pc <= 16'h0000;
        else       pc <= w_pc_next;
    end
endmodule

// File: tb/tb_processor.sv
// tb_processor.sv - directed self-checking bench for the processor core.
// Loads a hand-assembled program into imem and checks architectural state
// through hierarchical probes after each retired instruction.

module tb_processor;
    logic clk;
    logic reset;
    int   tests  = 0;
    int   failed = 0;

    processor dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Program image (index: word).
    localparam int PROG_LEN = 23;
    logic [15:0] prog [0:PROG_LEN-1] = '{
        16'h1205,  //  0 ADDI r1,r0,5
        16'h143D,  //  1 ADDI r2,r0,-3
        16'h3202,  //  2 SW   r1,2(r0)
        16'h2602,  //  3 LW   r3,2(r0)
        16'h0850,  //  4 ADD  r4,r1,r2
        16'h0A89,  //  5 SUB  r5,r2,r1
        16'h4242,  //  6 BEQ  r1,r1,+2  -> 9
        16'h1E01,  //  7 ADDI r7,r0,1   (skipped)
        16'h1E01,  //  8 ADDI r7,r0,1   (skipped)
        16'h0C8D,  //  9 SLT  r6,r2,r1
        16'h5242,  // 10 BNE  r1,r1,+2  (not taken)
        16'h1007,  // 11 ADDI r0,r0,7
        16'h7EAB,  // 12 LUI  r7,0xAB
        16'h0FCF,  // 13 SRL  r7,r7,r1
        16'h0B4E,  // 14 SLL  r5,r5,r1
        16'h0914,  // 15 XOR  r4,r4,r2
        16'h0C52,  // 16 AND  r6,r1,r2
        16'h0653,  // 17 OR   r3,r1,r2
        16'h6016,  // 18 JMP  22
        16'h1C09,  // 19 ADDI r6,r0,9   (skipped)
        16'hF000,  // 20 NOP, or HALT with HALT_EN
        16'h60FF,  // 21 JMP  255
        16'h52BD   // 22 BNE  r1,r2,-3  -> 20
    };

    // Trace: pc/instruction/opcode and signed registers each cycle.
    always @(negedge clk) begin
        $display("[TB] t=%0t pc=%0d instr=%h op=%h r1=%0d r2=%0d r3=%0d r4=%0d r5=%0d r6=%0d r7=%0d",
                 $time, dut.pc, dut.instruction, dut.opcode,
                 $signed(dut.regfile.reg_file[1]), $signed(dut.regfile.reg_file[2]),
                 $signed(dut.regfile.reg_file[3]), $signed(dut.regfile.reg_file[4]),
                 $signed(dut.regfile.reg_file[5]), $signed(dut.regfile.reg_file[6]),
                 $signed(dut.regfile.reg_file[7]));
    end

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] rf(input int idx);
        return dut.regfile.reg_file[idx];
    endfunction

    // One clock: rising edge, then settle to the falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        #1;
        for (int i = 0; i < PROG_LEN; i++) dut.imem[i] = prog[i];

        // Reset state.
        step();
        check("reset_pc", dut.pc, 16'd0);
        for (int i = 0; i < 8; i++) check($sformatf("reset_r%0d", i), rf(i), 16'h0000);
        check("fetch0_instr", dut.instruction, 16'h1205);
        check("fetch0_opcode", {12'h000, dut.opcode}, 16'h0001);
        reset = 1'b0;

        step(); check("addi_r1", rf(1), 16'h0005); check("pc1", dut.pc, 16'd1);
        step(); check("addi_neg_r2", rf(2), 16'hFFFD); check("pc2", dut.pc, 16'd2);
        step(); check("sw_mem2", dut.dmem.mem[2], 16'h0005); check("sw_no_r3", rf(3), 16'h0000);
                check("pc3", dut.pc, 16'd3);
        step(); check("lw_r3", rf(3), 16'h0005); check("pc4", dut.pc, 16'd4);
        step(); check("add_r4", rf(4), 16'h0002);
        step(); check("sub_r5", rf(5), 16'hFFF8); check("pc6", dut.pc, 16'd6);
        step(); check("beq_taken_pc", dut.pc, 16'd9); check("beq_skip_r7", rf(7), 16'h0000);
        step(); check("slt_r6", rf(6), 16'h0001); check("pc10", dut.pc, 16'd10);
        step(); check("bne_not_taken_pc", dut.pc, 16'd11);
        step(); check("r0_fixed", rf(0), 16'h0000); check("pc12", dut.pc, 16'd12);
        step(); check("lui_r7", rf(7), 16'hAB00);
        step(); check("srl_r7", rf(7), 16'h0558);
        step(); check("sll_r5", rf(5), 16'hFF00);
        step(); check("xor_r4", rf(4), 16'hFFFF);
        step(); check("and_r6", rf(6), 16'h0005);
        step(); check("or_r3", rf(3), 16'hFFFD); check("pc18", dut.pc, 16'd18);
        step(); check("jmp_pc", dut.pc, 16'd22);
        step(); check("bne_back_pc", dut.pc, 16'd20);
`ifdef HALT_EN
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("halt_pc_%0d", i), dut.pc, 16'd20);
        end
        check("halt_r6", rf(6), 16'h0005);
`else
        step(); check("op_f_nop_pc", dut.pc, 16'd21);
        step(); check("jmp255_pc", dut.pc, 16'd255);
        step(); check("wrap_pc", dut.pc, 16'd256);
                check("wrap_instr", dut.instruction, 16'h1205);
                check("skip19_r6", rf(6), 16'h0005);
`endif

        // Mid-program reset: state cleared, dmem kept, no write in reset cycles.
        reset = 1'b1;
        step(); check("rst2_pc", dut.pc, 16'd0); check("rst2_r1", rf(1), 16'h0000);
                check("rst2_mem2_kept", dut.dmem.mem[2], 16'h0005);
        step(); check("rst2_hold_pc", dut.pc, 16'd0); check("rst2_no_write_r1", rf(1), 16'h0000);
        reset = 1'b0;
        step(); check("rel_pc1", dut.pc, 16'd1); check("rel_r1", rf(1), 16'h0005);
        step(); check("rel_pc2", dut.pc, 16'd2); check("rel_r2", rf(2), 16'hFFFD);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
